// File: rtl/arm_fetch_unit_pkg.sv
// Shared definitions for the ARM instruction-fetch front end:
// the instruction width, the halt encoding and the fetch FSM states.
package arm_fetch_unit_pkg;

  localparam int          ARM_INST_W    = 32;
  localparam logic [31:0] ARM_HALT_INST = 32'he3a000bb;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_KILL   = 2'd1,
    ST_HSTOP  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  // True when a fetched word is the encoding that stops the front end.
  function automatic logic is_halt(input logic [ARM_INST_W-1:0] word,
                                   input logic [ARM_INST_W-1:0] halt_word);
    return word == halt_word;
  endfunction

endpackage

// File: rtl/arm_fetch_unit_fetch_queue.sv
// Prefetch queue: a small synchronous FIFO with wrap-around pointers.
// Flush empties it in one cycle and takes priority over push and pop.
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Entry storage; contents need no reset because occupancy gates their use.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/arm_fetch_unit.sv
// Instruction-fetch front end: issues word fetches over a req/ack handshake,
// buffers results with their PCs in a prefetch queue, handles branch
// redirects (killing an in-flight request) and stops on the halt encoding.
module arm_fetch_unit
  import arm_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       HALT_INST = ARM_HALT_INST
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic              halted
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int QW    = ADDR_W + ARM_INST_W;

  fetch_state_e      state;
  fetch_state_e      state_next;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] kill_addr;
  logic [ADDR_W-1:0] redirect_pc;
  logic              active;
  logic              redirect_take;
  logic              xfer;
  logic              q_push;
  logic              q_pop;
  logic              q_full;
  logic              q_empty;
  logic [CNT_W-1:0]  q_count;
  logic [QW-1:0]     q_head;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^redirect_addr[1:0];
  assign redirect_pc      = {redirect_addr[ADDR_W-1:2], 2'b00};
  assign redirect_take    = redirect_valid && (state != ST_HALTED);
  assign xfer             = imem_req && imem_ack;
  assign q_push           = xfer && (state == ST_RUN) && !redirect_take && !q_full;
  assign q_pop            = inst_valid && inst_ready && !redirect_take;
  assign inst_pc          = q_head[QW-1:ARM_INST_W];
  assign inst             = q_head[ARM_INST_W-1:0];

  fetch_queue #(
    .WIDTH (QW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .flush (redirect_take),
    .din   ({fetch_pc, imem_rdata}),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count),
    .head  (q_head)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_RUN;
    else      state <= state_next;
  end

  // Next-state logic: redirects steer RUN/KILL/HSTOP, halt stops fetch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_RUN: begin
        if (redirect_take)
          state_next = (imem_req && !imem_ack) ? ST_KILL : ST_RUN;
        else if (q_push && is_halt(imem_rdata, HALT_INST))
          state_next = ST_HSTOP;
      end
      ST_KILL: begin
        if (imem_ack) state_next = ST_RUN;
      end
      ST_HSTOP: begin
        if (redirect_take)
          state_next = ST_RUN;
        else if (q_pop && is_halt(inst, HALT_INST))
          state_next = ST_HALTED;
      end
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_RUN;
    endcase
  end

  // Output decode: requests in RUN while there is room, held throughout KILL.
  always_comb begin
    imem_req   = active && (((state == ST_RUN) && (q_count < CNT_W'(DEPTH))) ||
                            (state == ST_KILL));
    imem_addr  = (state == ST_KILL) ? kill_addr : fetch_pc;
    inst_valid = !q_empty && (state != ST_HALTED);
    halted     = (state == ST_HALTED);
  end

  // Fetch PC, the address held during a kill, and a one-cycle start gate after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc  <= RESET_PC;
      kill_addr <= RESET_PC;
      active    <= 1'b0;
    end else begin
      active <= 1'b1;
      if (redirect_take)
        fetch_pc <= redirect_pc;
      else if (q_push)
        fetch_pc <= fetch_pc + ADDR_W'(4);
      if ((state == ST_RUN) && redirect_take && imem_req && !imem_ack)
        kill_addr <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_arm_fetch_unit.sv
// Self-checking bench for arm_fetch_unit: a directed vector table, hand-written
// halt and reset sequences, and a randomized run against a transaction-level model.
module tb_arm_fetch_unit;

  localparam int          ADDR_W   = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] HALT     = 32'he3a000bb;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        halted;

  int          checks;
  int          failures;
  bit          haltEn;
  logic [31:0] haltAddr;

  typedef struct {
    bit          ack;
    bit          ready;
    bit          rv;
    logic [31:0] ra;
    bit          expReq;
    logic [31:0] expAddr;
    bit          expValid;
    logic [31:0] expPc;
  } vec_t;

  vec_t vecs[21];

  arm_fetch_unit #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .RESET_PC  (RESET_PC),
    .HALT_INST (HALT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: low bits 01 so ordinary words can never equal the halt encoding.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (haltEn && a == haltAddr) return HALT;
    return {a[29:0], 2'b01} ^ 32'h5a5a_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are driven just after a falling edge; memory returns the word at the current address.
  task automatic applyStimulus(input bit ack, input bit ready, input bit rv, input logic [31:0] ra);
    imem_ack       = ack;
    inst_ready     = ready;
    redirect_valid = rv;
    redirect_addr  = ra;
    imem_rdata     = memWord(imem_addr);
  endtask

  task automatic doReset();
    rst = 1'b0;
    applyStimulus(0, 0, 0, 32'h0);
    @(negedge clk);
    checkOutput("rst_req", imem_req, 0);
    checkOutput("rst_valid", inst_valid, 0);
    checkOutput("rst_halted", halted, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic runTable();
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      checkOutput($sformatf("vec%0d_req", i), imem_req, vecs[i].expReq);
      if (vecs[i].expReq) checkOutput($sformatf("vec%0d_addr", i), imem_addr, vecs[i].expAddr);
      checkOutput($sformatf("vec%0d_valid", i), inst_valid, vecs[i].expValid);
      if (vecs[i].expValid) begin
        checkOutput($sformatf("vec%0d_pc", i), inst_pc, vecs[i].expPc);
        checkOutput($sformatf("vec%0d_inst", i), inst, memWord(vecs[i].expPc));
      end
      applyStimulus(vecs[i].ack, vecs[i].ready, vecs[i].rv, vecs[i].ra);
    end
  endtask

  task automatic runHalt();
    haltEn   = 1'b1;
    haltAddr = 32'h8;
    doReset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("halt_fill_req", imem_req, 1);
      checkOutput("halt_fill_addr", imem_addr, 32'(4 * k));
      applyStimulus(1, 0, 0, 32'h0);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("halt_stop_req", imem_req, 0);
      checkOutput("halt_stop_valid", inst_valid, 1);
      applyStimulus(1, 0, 0, 32'h0);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("halt_drain_valid", inst_valid, 1);
      checkOutput("halt_drain_pc", inst_pc, 32'(4 * k));
      checkOutput("halt_drain_halted", halted, 0);
      applyStimulus(0, 1, 0, 32'h0);
    end
    @(negedge clk);
    checkOutput("halt_set", halted, 1);
    checkOutput("halt_set_valid", inst_valid, 0);
    checkOutput("halt_set_req", imem_req, 0);
    applyStimulus(0, 1, 1, 32'h40);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("halt_redir_halted", halted, 1);
      checkOutput("halt_redir_req", imem_req, 0);
      checkOutput("halt_redir_valid", inst_valid, 0);
      applyStimulus(0, 1, 0, 32'h0);
    end
    haltEn = 1'b0;
  endtask

  task automatic runMidReset();
    doReset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      applyStimulus(1, 0, 0, 32'h0);
    end
    @(negedge clk);
    checkOutput("mrst_pend_req", imem_req, 1);
    checkOutput("mrst_pend_addr", imem_addr, 32'hc);
    checkOutput("mrst_pend_valid", inst_valid, 1);
    applyStimulus(0, 0, 0, 32'h0);
    #2 rst = 1'b0;
    #1;
    checkOutput("mrst_req", imem_req, 0);
    checkOutput("mrst_valid", inst_valid, 0);
    checkOutput("mrst_halted", halted, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mrst_first_req", imem_req, 1);
    checkOutput("mrst_first_addr", imem_addr, RESET_PC);
    checkOutput("mrst_first_valid", inst_valid, 0);
  endtask

  // Randomized run: the model tracks the issue pointer, the expected consume PC,
  // the queue occupancy and whether an abandoned request is still outstanding.
  task automatic runRandom(input int cycles);
    logic [31:0] fetchPtr;
    logic [31:0] expPc;
    int          occ;
    bit          killing;
    bit          pend;
    logic [31:0] pendAddr;
    int          lat;
    bit          armed;
    bit          ack;
    bit          ready;
    bit          rv;
    logic [31:0] ra;
    doReset();
    fetchPtr = RESET_PC;
    expPc    = RESET_PC;
    occ      = 0;
    killing  = 0;
    pend     = 0;
    pendAddr = 32'h0;
    lat      = 0;
    armed    = 0;
    @(negedge clk);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (pend) begin
        checkOutput("rnd_hold_req", imem_req, 1);
        checkOutput("rnd_hold_addr", imem_addr, pendAddr);
      end
      checkOutput("rnd_req_rule", imem_req, (killing || occ < DEPTH));
      checkOutput("rnd_valid", inst_valid, (occ > 0));
      if (imem_req) begin
        if (!armed) begin
          lat   = int'($urandom_range(0, 3));
          armed = 1;
        end
        ack = (lat == 0);
        if (!ack) lat--;
      end else begin
        ack = ($urandom_range(0, 9) == 0);
      end
      ready = ($urandom_range(0, 3) != 0);
      rv    = ($urandom_range(0, 15) == 0);
      ra    = $urandom;
      applyStimulus(ack, ready, rv, ra);
      if (inst_valid && ready && !rv) begin
        checkOutput("rnd_pc", inst_pc, expPc);
        checkOutput("rnd_inst", inst, memWord(expPc));
        expPc = expPc + 32'd4;
        occ--;
      end
      if (rv) begin
        fetchPtr = ra & ~32'h3;
        expPc    = fetchPtr;
        occ      = 0;
        killing  = imem_req && !ack;
      end else if (imem_req && ack) begin
        if (killing) begin
          killing = 0;
        end else begin
          checkOutput("rnd_fetch_addr", imem_addr, fetchPtr);
          fetchPtr = fetchPtr + 32'd4;
          occ++;
        end
      end
      if (imem_req && ack) armed = 0;
      pend     = imem_req && !ack;
      pendAddr = imem_addr;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    haltEn   = 1'b0;
    haltAddr = 32'h0;
    //          ack   rdy   rv    ra            req   addr          vld   pc
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,       1'b1, 32'h0,        1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,       1'b1, 32'h4,        1'b1, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b1, 32'h8,        1'b1, 32'h4};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'hc,        1'b1, 32'h4};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b1, 32'hc,        1'b1, 32'h4};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b1, 32'h10,       1'b1, 32'h4};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b1, 32'h4};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b1, 32'h4};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,       1'b0, 32'h0,        1'b1, 32'h4};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,       1'b1, 32'h14,       1'b1, 32'h8};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h0,       1'b1, 32'h14,       1'b1, 32'hc};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0,       1'b1, 32'h18,       1'b1, 32'h10};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 32'h103,     1'b1, 32'h18,       1'b1, 32'h14};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 32'h0,       1'b1, 32'h18,       1'b0, 32'h0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 32'h0,       1'b1, 32'h18,       1'b0, 32'h0};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 32'h0,       1'b1, 32'h18,       1'b0, 32'h0};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 32'h0,       1'b1, 32'h100,      1'b0, 32'h0};
    vecs[17] = '{1'b1, 1'b1, 1'b1, 32'h20a,     1'b1, 32'h104,      1'b1, 32'h100};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 32'h0,       1'b1, 32'h208,      1'b0, 32'h0};
    vecs[19] = '{1'b1, 1'b1, 1'b0, 32'h0,       1'b1, 32'h208,      1'b0, 32'h0};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h20c,      1'b1, 32'h208};

    $display("[TB] directed vector table");
    doReset();
    runTable();
    $display("[TB] halt sequence");
    runHalt();
    $display("[TB] reset during an outstanding request");
    runMidReset();
    $display("[TB] randomized run");
    runRandom(2000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
